dmem_mmio_responder: RTL
========================

Name: dmem_mmio_responder

Overview:
- Responder for the CPU data-memory port: receives word address, write data and write enable; returns registered read data one cycle later.
- Decodes each access to on-chip RAM or to a small MMIO register block.
- MMIO block has a console transmit FIFO with a valid/ready byte stream, a free-running cycle counter and a halt/exit-code register.
- Sits between the CPU core and the top level, replacing the plain data RAM.

Parameters:
- RAM_WORDS, 4096, number of 32-bit RAM words; power of two.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dmem_addr  in  32  word address from CPU.
- dmem_d  in  32  write data.
- dmem_we  in  1  write strobe; one access per asserted cycle.
- dmem_q  out  32  read data, registered.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  8  byte at the FIFO head.
- tx_ready  in  1  downstream accepts a byte.
- halt_req  out  1  sticky halt request.
- exit_code  out  32  value written to HALT.

Behaviour:
- Reset (async, rst_n=0):
  - dmem_q=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0, cycle counter=0, halt_req=0, exit_code=0.
  - RAM contents are not cleared.
- Decode:
  - addr[31:28]==4'hF selects MMIO; addr[3:0] is the register offset.
  - Any other address selects RAM at index addr mod RAM_WORDS, so out-of-range addresses wrap.
- Read latency:
  - dmem_q is updated every cycle with the data for the address present at that edge, one cycle latency, for both RAM and MMIO.
  - On a write cycle, dmem_q returns the old contents (read-before-write).
  - Reads have no side effects, so an undriven or floating address with we=0 is harmless.
- MMIO registers (offset: read / write):
  - 0 TX_DATA: reads 0. A write pushes dmem_d[7:0] into the FIFO.
  - 1 TX_STATUS: read returns bit0=full, bit1=empty, bit2=overflow (sticky), bits[15:8]=count. Any write clears overflow.
  - 2 CYCLE: read returns the counter value at the request edge. A write loads 0; the counter increments from the next edge.
  - 3 HALT: reads exit_code. A write with dmem_d[0]=1 sets halt_req and latches exit_code=dmem_d. Writes with bit0=0 are ignored. Once set, halt_req holds until reset and later HALT writes are ignored.
  - Offsets 4..15: read 0, writes ignored.
- TX FIFO:
  - Circular buffer, read/write pointers plus count.
  - tx_data is the head entry, driven from registers.
  - Pop when tx_valid && tx_ready.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (count unchanged, pointers both advance).
  - A push to a full FIFO with no pop is dropped, sets overflow and leaves count unchanged.
  - Push and pop together on an empty FIFO: the push is accepted, the pop does not occur (tx_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH.
- Cycle counter: 32-bit, +1 per clock, wraps from 0xFFFFFFFF to 0. The write-clear takes priority over the increment.
- RAM: synchronous single-port, write when dmem_we and RAM is selected.
- Reset mid-operation: FIFO contents are discarded immediately; tx_valid drops asynchronously.

Optional Feature:
- Macro DMEM_CYCLE_COUNTER_EN.
- Defined: CYCLE register implemented as above.
- Undefined: no counter flops; offset 2 reads 0 and writes are ignored; everything else unchanged.

Test Plan:
- Write RAM addr 5 = 0xDEADBEEF, then read addr 5 → dmem_q=0xDEADBEEF one cycle after the read edge. Read addr 5+RAM_WORDS → same value (wrap).
- Hold tx_ready=0, write 0x41 then 0x42 to 0xF0000000 → tx_valid=1, tx_data=0x41, TX_STATUS count=2. Raise tx_ready for one cycle → tx_data=0x42, count=1.
- Fill FIFO with 16 bytes (tx_ready=0), write a 17th → STATUS reads full=1, overflow=1, count=16. Write STATUS → overflow=0. With the FIFO full, push and pop in the same cycle → count stays 16, the new byte lands at the tail.
- Write CYCLE (0xF0000002) at edge N, read at edge N+3 → 3 (DMEM_CYCLE_COUNTER_EN defined). Rebuild without the macro → read returns 0.
- Write HALT = 0x00000054 → halt_req=0. Write 0x0000002B → halt_req=1, exit_code=0x2B. Write 0x3 → exit_code stays 0x2B. Assert rst_n=0 → halt_req=0 immediately.
- Assert reset with the FIFO holding 3 bytes and the counter at 1000 → tx_valid=0, counter=0, dmem_q=0 without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// CPU data-memory responder: wrapping on-chip RAM plus an MMIO block (TX FIFO, cycle counter, halt).
// Optional macro DMEM_CYCLE_COUNTER_EN enables the free-running CYCLE register at offset 2.
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_d,
  input  logic        dmem_we,
  output logic [31:0] dmem_q,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt_req,
  output logic [31:0] exit_code
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [3:0] {
    OFF_TX_DATA   = 4'd0,
    OFF_TX_STATUS = 4'd1,
    OFF_CYCLE     = 4'd2,
    OFF_HALT      = 4'd3
  } mmio_off_e;

  logic            mmio_sel;
  mmio_off_e       off;
  logic [AW-1:0]   ram_idx;
  logic [31:0]     ram [RAM_WORDS];

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            full;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic [8:0]      count9;

  logic [31:0]     status;
  logic [31:0]     cycle_rd;
  logic [31:0]     mmio_rdata;
  logic            unused_bits;

  assign mmio_sel    = (dmem_addr[31:28] == 4'hF);
  assign off         = mmio_off_e'(dmem_addr[3:0]);
  assign ram_idx     = dmem_addr[AW-1:0];
  assign unused_bits = ^{dmem_addr, count9[8]};

  // RAM: no reset, write only when RAM is selected
  always_ff @(posedge clk) begin
    if (dmem_we && !mmio_sel)
      ram[ram_idx] <= dmem_d;
  end

  // TX FIFO
  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : '0;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_sel && dmem_we && (off == OFF_TX_DATA);
  // When full, a simultaneous pop frees the head slot, which wr_ptr aliases.
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= dmem_d[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (mmio_sel && dmem_we && (off == OFF_TX_STATUS))
        overflow <= 1'b0;
      else if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  assign count9 = 9'(count);
  assign status = {16'h0000, count9[7:0], 5'b00000, overflow, !tx_valid, full};

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_q <= '0;
    else if (mmio_sel && dmem_we && (off == OFF_CYCLE))
      cycle_q <= '0;
    else
      cycle_q <= cycle_q + 32'd1;
  end

  // Reads report the count including the request edge itself.
  assign cycle_rd = cycle_q + 32'd1;
`else
  assign cycle_rd = '0;
`endif

  // Halt / exit code, sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_req  <= 1'b0;
      exit_code <= '0;
    end else if (mmio_sel && dmem_we && (off == OFF_HALT) && dmem_d[0] && !halt_req) begin
      halt_req  <= 1'b1;
      exit_code <= dmem_d;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_TX_STATUS: mmio_rdata = status;
      OFF_CYCLE:     mmio_rdata = cycle_rd;
      OFF_HALT:      mmio_rdata = exit_code;
      default:       mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dmem_q <= '0;
    else
      dmem_q <= mmio_sel ? mmio_rdata : ram[ram_idx];
  end

endmodule
